moore_1011_detector: RTL and testbench

//   Serial bit-stream pattern detector for the sequence 1-0-1-1, built as a Moore FSM.
//   It samples one input bit per clock and raises detector_out for one state period after 1011 is seen.

---
 rtl/moore_1011_pkg.sv | 14 +
 rtl/moore_1011_detector_if.sv | 36 +++
 rtl/moore_1011_sat_cnt.sv | 19 +
 rtl/moore_1011_detector.sv | 61 ++++++
 tb/tb_moore_1011_detector.sv | 116 +++++++++++
 5 files changed

// File: rtl/moore_1011_pkg.sv
// Shared types and constants for the 1011 Moore sequence detector.
package moore_1011_pkg;

    typedef enum logic [2:0] {
        S0    = 3'd0,
        S1    = 3'd1,
        S10   = 3'd2,
        S101  = 3'd3,
        S1011 = 3'd4
    } state_t;

    localparam logic [3:0] PATTERN = 4'b1011;

endpackage

// File: rtl/moore_1011_detector_if.sv
// Serial bit in / detection flag out bundle for the 1011 detector.
// det_count is present only when MOORE_1011_CNT_EN is defined.
interface moore_1011_detector_if #(
    parameter int unsigned CNT_W = 8
);

    logic             sequence_in;
    logic             detector_out;
`ifdef MOORE_1011_CNT_EN
    logic [CNT_W-1:0] det_count;
`endif

    modport master (
        output sequence_in,
        input  detector_out
`ifdef MOORE_1011_CNT_EN
        ,
        input  det_count
`endif
    );

    modport slave (
        input  sequence_in,
        output detector_out
`ifdef MOORE_1011_CNT_EN
        ,
        output det_count
`endif
    );

    // A zero-width counter cannot be built.
    if (CNT_W == 0) begin : g_bad_cnt_w
        $error("moore_1011_detector_if: CNT_W must be at least 1");
    end

endinterface

// File: rtl/moore_1011_sat_cnt.sv
// Saturating up-counter: counts inc pulses, sticks at all-ones, cleared by async reset.
module moore_1011_sat_cnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/moore_1011_detector.sv
// Moore FSM flagging each (overlapping) occurrence of 1011 on a serial bit stream.
// Optional saturating detection counter enabled by MOORE_1011_CNT_EN.
module moore_1011_detector
    import moore_1011_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    moore_1011_detector_if.slave  bus
);

    state_t state;
    state_t next_state;
    logic   det_q;

    // State register; det_q mirrors (state == S1011) as a dedicated flop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S0;
            det_q <= 1'b0;
        end else begin
            state <= next_state;
            det_q <= (next_state == S1011);
        end
    end

    // Next state; unused codes 5..7 fall back to S0.
    always_comb begin
        next_state = S0;
        case (state)
            S0:      next_state = (bus.sequence_in == PATTERN[3]) ? S1    : S0;
            S1:      next_state = (bus.sequence_in == PATTERN[2]) ? S10   : S1;
            S10:     next_state = (bus.sequence_in == PATTERN[1]) ? S101  : S0;
            S101:    next_state = (bus.sequence_in == PATTERN[0]) ? S1011 : S10;
            S1011:   next_state = bus.sequence_in ? S1 : S10;
            default: next_state = S0;
        endcase
    end

    assign bus.detector_out = det_q;

`ifdef MOORE_1011_CNT_EN
    logic hit;
    assign hit = (next_state == S1011);

    moore_1011_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_sat_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (hit),
        .count (bus.det_count)
    );
`endif

    if (CNT_W == 0) begin : g_bad_cnt_w
        $error("moore_1011_detector: CNT_W must be at least 1");
    end

endmodule

// File: tb/tb_moore_1011_detector.sv
// Scoreboard bench for moore_1011_detector; count checks active with MOORE_1011_CNT_EN.
module tb_moore_1011_detector;

    localparam int unsigned CNT_W = 2;

    typedef struct packed {
        logic             rst;
        logic             din;
        logic             det;
        logic [CNT_W-1:0] cnt;
    } step_t;

    typedef struct packed {
        logic             det;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clock;
    logic reset;

    step_t vec[$];
    exp_t  exp_q[$];

    int checks   = 0;
    int failures = 0;

    moore_1011_detector_if #(.CNT_W(CNT_W)) bus ();

    moore_1011_detector #(.CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Append one directed segment: reset level, input bits, expected flag and count digits.
    task automatic add_seq(input logic r, input string bits, input string dets, input string cnts);
        step_t s;
        for (int i = 0; i < bits.len(); i++) begin
            s.rst = r;
            s.din = (bits[i] == "1");
            s.det = (dets[i] == "1");
            s.cnt = CNT_W'(cnts[i] - "0");
            vec.push_back(s);
        end
    endtask

    // Monitor: one expected output per clock, sampled after the edge settles.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.detector_out !== e.det) begin
                    failures++;
                    $display("FAIL detector_out at %0t: got %b expected %b", $time, bus.detector_out, e.det);
                end
`ifdef MOORE_1011_CNT_EN
                checks++;
                if (bus.det_count !== e.cnt) begin
                    failures++;
                    $display("FAIL det_count at %0t: got %0d expected %0d", $time, bus.det_count, e.cnt);
                end
`endif
            end
        end
    end

    // Driver: apply one step per falling edge and queue its expected post-edge result.
    initial begin
        int wait_cycles;
        reset           = 1'b0;
        bus.sequence_in = 1'b0;

        add_seq(1'b0, "000",       "000",       "000");        // reset held
        add_seq(1'b1, "00",        "00",        "00");         // release, stay in S0
        add_seq(1'b1, "101101100", "000100100", "000111222");  // overlap
        add_seq(1'b1, "10011",     "00000",     "22222");      // near miss
        add_seq(1'b1, "110100",    "000000",    "222222");     // near miss
        add_seq(1'b1, "101",       "000",       "222");        // partial pattern
        add_seq(1'b0, "0",         "0",         "0");          // mid-pattern reset
        add_seq(1'b1, "100",       "000",       "000");        // progress discarded
        add_seq(1'b1, "101100",    "000100",    "000111");     // basic
        add_seq(1'b0, "0",         "0",         "0");
        add_seq(1'b1, "1011101110111011101100",
                      "0001000100010001000100",
                      "0001111222233333333333");               // saturation

        foreach (vec[i]) begin
            @(negedge clock);
            reset           = vec[i].rst;
            bus.sequence_in = vec[i].din;
            exp_q.push_back('{det: vec[i].det, cnt: vec[i].cnt});
        end

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(negedge clock);
            wait_cycles++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected outputs left, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
